// File: rtl/chooser_rr.sv
// N-way registered chooser: fixed-select or round-robin arbitration into one
// output register, valid/ready on both sides, one word per clock at full rate.
module chooser_rr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    gnt_data;
  logic [SEL_W-1:0]    cand;
  logic                load_en;
  logic                xfer;

  assign load_en = !out_valid || out_ready;

  // Pick the winning channel; round-robin starts just past the last winner
  // so the nearest valid channel after rr_ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (!mode) begin
      if (int'(sel) < CHANNELS) begin
        gnt_idx = sel;
        gnt_any = in_valid[sel];
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
        if (!gnt_any && in_valid[cand]) begin
          gnt_idx = cand;
          gnt_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant    = '0;
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_any && gnt_idx == SEL_W'(i)) begin
        grant[i] = 1'b1;
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = grant & {CHANNELS{load_en}};
  assign xfer     = gnt_any && load_en;

  // Output register: load on transfer, otherwise drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
      rr_ptr    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/chooser_rr.md
Name: chooser_rr

Overview:
- Parametrised, registered N-way successor to the team's 4-bit 2:1 chooser: selects one of CHANNELS input channels of WIDTH bits and drives it into a single registered output with valid/ready handshakes on both sides.
- Two modes: fixed select (the sel input picks the channel, as the 2:1 chooser did) and round-robin arbitration across all valid channels.
- Sits between multiple producers (e.g. switch/sensor capture blocks) and one shared consumer (display or UART path).

Parameters:
- WIDTH, 4, data width per channel.
- CHANNELS, 4, number of input channels, 2..16.
- SEL_W, 2, select/channel-index width, must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational).
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the channel held in out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1, so channel 0 has first priority after reset. Reset mid-transfer discards the held word with no replay.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en=1.
- Grant (combinational, one-hot, at most one bit):
  - mode=0: grant[sel] = in_valid[sel]. No grant if sel >= CHANNELS. Other channels are never granted.
  - mode=1: the first i with in_valid[i]=1, searching from (rr_ptr+1) mod CHANNELS upward with wrap-around.
- in_ready[i] = grant[i] && load_en. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer at a clock edge:
  - out_data <= channel i data; out_chan <= i; out_valid <= 1; rr_ptr <= i.
  - rr_ptr updates in both modes.
- On a clock edge with no transfer but out_valid && out_ready: out_valid <= 0. out_data and out_chan hold their last values.
- While out_valid && !out_ready: out_data, out_chan and out_valid hold stable. All in_ready are 0.
- Simultaneous consume and load in the same cycle is allowed, giving full throughput of one word per clock.
- Latency: one clock from the input transfer edge to out_valid=1.
- mode or sel changes take effect in the same cycle's grant, since grant is combinational. A word already in the output register is unaffected.
- Producers must hold in_data and in_valid until accepted. The block does not check for this.
- No combinational path from out_ready to out_data. in_ready depends combinationally on out_ready, in_valid, mode and sel.

Test Plan:
- Reset then idle: assert rst mid-cycle with out_valid=1 -> out_valid, out_data and out_chan go to 0 immediately with no clock edge, and all in_ready=0 while in_valid=0.
- Fixed mode, CHANNELS=4, WIDTH=4: mode=0, sel=2, in_data channels = {3:0xD, 2:0xC, 1:0xB, 0:0xA}, all valid, out_ready=1 -> out_data=0xC and out_chan=2 one cycle later; in_ready=4'b0100; sel=0 next cycle -> out_data=0xA.
- Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid=1 throughout.
- Round-robin skip and wrap: mode=1, in_valid=4'b1001, rr_ptr=3 after reset -> grants 0,3,0,3 alternating; channels 1 and 2 never granted.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_chan stable, in_ready=0; out_ready=1 -> the next word loads the same cycle, with no bubble and no duplicate.
- Out-of-range select: CHANNELS=3, SEL_W=2, mode=0, sel=3, all valid -> in_ready=0 and out_valid stays 0 indefinitely.
